// File: rtl/systolic_writeback.sv
// systolic_writeback: drains the 8x8 MAC array diagonal by diagonal, requantizes
// each accumulator to int8 and writes the buffered tile to SRAM one row per cycle.
module systolic_writeback #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int OUTCOME_WIDTH = 21,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic clk,
  input  logic srst,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [3:0] frac_shift,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic [5:0] matrix_index,
  output logic sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata0,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata1,
  output logic busy,
  output logic done
);
  localparam int N = ARRAY_SIZE;
  localparam int OW = OUTCOME_WIDTH;
  localparam logic signed [OW:0] MAX_V = 127;
  localparam logic signed [OW:0] MIN_V = -128;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FIN} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, row;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [3:0] shift_q, shift_d;
  logic wen_q, wen_d;
  logic [SRAM_DATA_WIDTH-1:0] wd0_q, wd0_d, wd1_q, wd1_d;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic [N-1:0][DATA_WIDTH-1:0] q_byte;
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [OW:0] x, rnd, t;
    assign x = $signed({mul_outcome[i*OW+OW-1], mul_outcome[i*OW +: OW]});
    assign rnd = (OW+1)'(1) << (shift_q - 4'd1);
    assign t = shift_q == 4'd0 ? x : (x + rnd) >>> shift_q;
    assign q_byte[i] = t > MAX_V ? 8'h7f : t < MIN_V ? 8'h80 : t[7:0];
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      shift_q <= '0;
      wen_q <= 1'b0;
      addr_q <= '0;
      wd0_q <= '0;
      wd1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      shift_q <= shift_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      wd0_q <= wd0_d;
      wd1_q <= wd1_d;
    end
  end
  always_ff @(posedge clk) buf_q <= buf_d;
  always_comb begin
    state_d = state_q == IDLE    ? (start ? COLLECT : IDLE) :
              state_q == COLLECT ? (cnt_q == 3'd7 ? WRITE : COLLECT) :
              state_q == WRITE   ? (cnt_q == 3'd7 ? FIN : WRITE) : IDLE;
    cnt_d = (state_q == COLLECT || state_q == WRITE) ? cnt_q + 3'd1 : 3'd0;
    base_d = (state_q == IDLE && start) ? base_addr : base_q;
    shift_d = (state_q == IDLE && start) ? frac_shift : shift_q;
  end
  // Row 0 is loaded on the last collect edge, so it must see that edge's bytes via buf_d.
  always_comb begin
    buf_d = buf_q;
    if (state_q == COLLECT)
      for (int i = 0; i < N; i++) buf_d[i][cnt_q - 3'(i)] = q_byte[i];
    row = state_q == COLLECT ? 3'd0 : cnt_q + 3'd1;
    wen_d = (state_q == COLLECT && cnt_q == 3'd7) || (state_q == WRITE && cnt_q != 3'd7);
    addr_d = wen_d ? base_q + ADDR_WIDTH'(row) : addr_q;
    wd0_d = wen_d ? {buf_d[row][0], buf_d[row][1], buf_d[row][2], buf_d[row][3]} : wd0_q;
    wd1_d = wen_d ? {buf_d[row][4], buf_d[row][5], buf_d[row][6], buf_d[row][7]} : wd1_q;
  end
  always_comb begin
    matrix_index = state_q == COLLECT ? {3'd0, cnt_q} : 6'd0;
    busy = state_q != IDLE;
    done = state_q == FIN;
    sram_wen = wen_q;
    sram_addr = addr_q;
    sram_wdata0 = wd0_q;
    sram_wdata1 = wd1_q;
  end
endmodule

// File: tb/tb_systolic_writeback.sv
// tb_systolic_writeback: directed tiles against hand-computed SRAM writes,
// with the MAC array modelled as a diagonal-indexed lookup of a C matrix.
module tb_systolic_writeback;
  logic clk = 1'b0, srst = 1'b1, start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [3:0] frac_shift = '0;
  logic [167:0] mul_outcome;
  logic [5:0] matrix_index;
  logic sram_wen, busy, done;
  logic [9:0] sram_addr;
  logic [31:0] sram_wdata0, sram_wdata1;
  int cm [8][8];
  int vectors = 0, miscompares = 0;
  logic wen_log [64], busy_log [64], done_log [64];
  logic [9:0] addr_log [64];
  logic [5:0] idx_log [64];
  logic [31:0] d0_log [64], d1_log [64];

  systolic_writeback dut (.clk(clk), .srst(srst), .start(start), .base_addr(base_addr),
    .frac_shift(frac_shift), .mul_outcome(mul_outcome), .matrix_index(matrix_index),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata0(sram_wdata0),
    .sram_wdata1(sram_wdata1), .busy(busy), .done(done));

  always #5 clk = ~clk;

  always_comb begin
    mul_outcome = '0;
    for (int i = 0; i < 8; i++) mul_outcome[i*21 +: 21] = 21'(cm[i][(int'(matrix_index) - i) & 7]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [9:0] base, input logic [3:0] sh, input logic [63:0] start_mask,
                     input int rst_cyc, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start = start_mask[c];
      srst = (c == rst_cyc);
      base_addr = start_mask[c] ? base : 10'h2aa;
      frac_shift = start_mask[c] ? sh : 4'hf;
      @(negedge clk);
      wen_log[c] = sram_wen;
      busy_log[c] = busy;
      done_log[c] = done;
      addr_log[c] = sram_addr;
      idx_log[c] = matrix_index;
      d0_log[c] = sram_wdata0;
      d1_log[c] = sram_wdata1;
    end
    start = 1'b0;
    srst = 1'b0;
  endtask

  task automatic set_row0(input int v0, v1, v2, v3, v4);
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) cm[i][j] = 0;
    cm[0][0] = v0; cm[0][1] = v1; cm[0][2] = v2; cm[0][3] = v3; cm[0][4] = v4;
  endtask

  initial begin
    int n;
    logic [9:0] wrap_addr [8];
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) cm[i][j] = i * 8 + j;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wen", 32'(sram_wen), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset addr", 32'(sram_addr), 0);
    chk("reset wdata0", sram_wdata0, 0);
    chk("reset wdata1", sram_wdata1, 0);
    chk("reset index", 32'(matrix_index), 0);
    srst = 1'b0;

    // identity-like tile C[i][j] = 8i+j, no shift
    run(10'h040, 4'd0, 64'h1, -1, 20);
    chk("busy c0", 32'(busy_log[0]), 0);
    chk("busy c1", 32'(busy_log[1]), 1);
    chk("busy c17", 32'(busy_log[17]), 1);
    chk("busy c18", 32'(busy_log[18]), 0);
    for (int c = 1; c <= 8; c++) chk($sformatf("index c%0d", c), 32'(idx_log[c]), 32'(c - 1));
    chk("index c9", 32'(idx_log[9]), 0);
    chk("wen c8", 32'(wen_log[8]), 0);
    chk("wen c17", 32'(wen_log[17]), 0);
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("wen row%0d", r), 32'(wen_log[9+r]), 1);
      chk($sformatf("addr row%0d", r), 32'(addr_log[9+r]), 32'h40 + 32'(r));
      chk($sformatf("wdata0 row%0d", r), d0_log[9+r],
          {8'(8*r), 8'(8*r+1), 8'(8*r+2), 8'(8*r+3)});
      chk($sformatf("wdata1 row%0d", r), d1_log[9+r],
          {8'(8*r+4), 8'(8*r+5), 8'(8*r+6), 8'(8*r+7)});
    end
    chk("row2 wdata0", d0_log[11], 32'h10111213);
    chk("row2 wdata1", d1_log[11], 32'h14151617);
    chk("done c16", 32'(done_log[16]), 0);
    chk("done c17", 32'(done_log[17]), 1);
    chk("done c18", 32'(done_log[18]), 0);
    chk("hold addr c18", 32'(addr_log[18]), 32'h47);

    // rounding, shift 2
    set_row0(5, 6, -5, -6, -7);
    run(10'h100, 4'd2, 64'h1, -1, 20);
    chk("round wdata0", d0_log[9], 32'h0102ffff);
    chk("round wdata1", d1_log[9], 32'hfe000000);

    // saturation, shift 0
    set_row0(1000, -1000, 127, -128, 128);
    run(10'h100, 4'd0, 64'h1, -1, 20);
    chk("sat wdata0", d0_log[9], 32'h7f807f80);
    chk("sat wdata1", d1_log[9], 32'h7f000000);

    // start re-pulsed at cycles 5 and 17 (ignored) and 18 (accepted)
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) cm[i][j] = i * 8 + j;
    run(10'h200, 4'd0, (64'h1 << 0) | (64'h1 << 5) | (64'h1 << 17) | (64'h1 << 18), -1, 40);
    n = 0;
    for (int c = 0; c <= 18; c++) n += int'(wen_log[c]);
    chk("restart write count", 32'(n), 8);
    n = 0;
    for (int c = 0; c <= 18; c++) n += int'(done_log[c]);
    chk("restart done count", 32'(n), 1);
    chk("restart busy c19", 32'(busy_log[19]), 1);
    chk("restart wen c27", 32'(wen_log[27]), 1);
    chk("restart addr c27", 32'(addr_log[27]), 32'h200);
    chk("restart done c35", 32'(done_log[35]), 1);

    // reset during WRITE
    run(10'h080, 4'd0, 64'h1, 11, 22);
    chk("rst wen c9", 32'(wen_log[9]), 1);
    chk("rst wen c10", 32'(wen_log[10]), 1);
    chk("rst addr c10", 32'(addr_log[10]), 32'h81);
    for (int c = 12; c < 22; c++) begin
      chk($sformatf("rst wen c%0d", c), 32'(wen_log[c]), 0);
      chk($sformatf("rst busy c%0d", c), 32'(busy_log[c]), 0);
    end
    n = 0;
    for (int c = 0; c < 22; c++) n += int'(done_log[c]);
    chk("rst no done", 32'(n), 0);
    chk("rst addr c12", 32'(addr_log[12]), 0);
    chk("rst wdata0 c12", d0_log[12], 0);

    // address wrap
    wrap_addr = '{10'h3fe, 10'h3ff, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
    run(10'h3fe, 4'd0, 64'h1, -1, 20);
    for (int r = 0; r < 8; r++)
      chk($sformatf("wrap addr row%0d", r), 32'(addr_log[9+r]), 32'(wrap_addr[r]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
